// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Groups the two buses of the instruction-memory loader:
//   * byte stream  : byte_valid / byte_data (source -> loader), byte_ready (loader -> source)
//   * write port   : wr_en / wr_addr / wr_data (loader -> instruction memory)
// Modports:
//   slave  : the loader (consumes bytes, drives the memory write port)
//   master : the environment (byte source plus memory write-port observer)
// -----------------------------------------------------------------------------
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Write-side companion to a single-cycle processor's instruction memory.
// Receives a program as a byte stream, packs bytes little-endian into 32-bit
// words and issues one write strobe per complete word. The processor is held
// in stall (o_cpu_hold) until a full program has been written.
//
// Ports:
//   clk           processor clock, rising edge
//   rst_n         synchronous active-low reset
//   i_load_start  one-cycle load request, honoured only in IDLE
//   i_load_len    number of words to load, sampled with i_load_start
//   i_abort       cancels a load in progress (RECV/WRITE)
//   bus           byte stream in + instruction-memory write port out
//   o_cpu_hold    stalls processor fetch while high
//   o_load_done   sticky: last load completed
//   o_load_err    sticky: last request rejected or aborted
//
// Timing: a word takes 4 accept cycles plus 1 WRITE cycle. The write strobe is
// registered on the way out of WRITE, so it is visible in the cycle after WRITE
// (the first RECV cycle of the next word, or the DONE cycle). This lets an
// abort seen in WRITE suppress the strobe entirely.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_start,
  input  logic [LEN_W-1:0]  i_load_len,
  input  logic              i_abort,
  imem_loader_if.slave      bus,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_word_idx;
  logic [1:0]         r_byte_idx;
  logic [31:0]        r_asm;
  logic               r_byte_ready;
  logic               r_wr_en;
  logic [31:0]        r_wr_addr;
  logic [31:0]        r_wr_data;
  logic               r_cpu_hold;
  logic               r_load_done;
  logic               r_load_err;

  logic               w_len_ok;
  logic               w_accept;
  logic               w_last_word;

  assign w_len_ok    = (i_load_len != '0) && (i_load_len <= LEN_W'(DEPTH));
  assign w_accept    = (r_state == S_RECV) && bus.byte_valid && r_byte_ready;
  assign w_last_word = (LEN_W'(r_word_idx) == (r_len - LEN_W'(1)));

  // NOTE: all state lives in one clocked block with non-blocking assignments,
  // so every register samples pre-edge values and the block order is irrelevant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_hold   <= 1'b1;  // processor stays stalled until the first good load
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low each cycle so it can only ever be a
      // single-cycle pulse; only the WRITE branch raises it.
      r_wr_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_load_start) begin
            if (w_len_ok) begin
              r_len        <= i_load_len;
              r_word_idx   <= '0;
              r_byte_idx   <= '0;
              r_cpu_hold   <= 1'b1;
              r_load_done  <= 1'b0;
              r_load_err   <= 1'b0;
              r_byte_ready <= 1'b1;
              r_state      <= S_RECV;
            end else begin
              // Rejected request: hold and done keep their previous values.
              r_load_err <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (i_abort) begin
            r_byte_ready <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_load_err   <= 1'b1;
            r_state      <= S_IDLE;
          end else if (w_accept) begin
            r_asm[{r_byte_idx, 3'b000} +: 8] <= bus.byte_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_byte_ready <= 1'b0;
              r_state      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (i_abort) begin
            // Abort wins over the write: the completed word is dropped.
            r_cpu_hold <= 1'b1;
            r_load_err <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= 32'({r_word_idx, 2'b00});
            r_wr_data <= r_asm;
            if (w_last_word) begin
              r_state <= S_DONE;
            end else begin
              r_word_idx   <= r_word_idx + IDX_W'(1);
              r_byte_idx   <= '0;
              r_byte_ready <= 1'b1;
              r_state      <= S_RECV;
            end
          end
        end

        S_DONE: begin
          r_load_done <= 1'b1;
          r_cpu_hold  <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_load_done    = r_load_done;
  assign o_load_err     = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed testbench for imem_loader. Inputs change and outputs are observed on
// the falling clock edge; the DUT acts on the rising edge. A monitor records
// every write strobe so each scenario can compare the written words against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_start = 1'b0;
  logic [6:0] load_len = '0;
  logic       abort = 1'b0;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader_if bif ();

  imem_loader #(
    .DEPTH (64),
    .LEN_W (7)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (load_start),
    .i_load_len   (load_len),
    .i_abort      (abort),
    .bus          (bif),
    .o_cpu_hold   (cpu_hold),
    .o_load_done  (load_done),
    .o_load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.wr_en === 1'b1) begin
      wa_q.push_back(bif.wr_addr);
      wd_q.push_back(bif.wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------- helpers
  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic start_load(input logic [6:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    bif.byte_valid = 1'b1;
    bif.byte_data  = d;
    while (bif.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_byte_timeout: byte_ready=%0b want 1", bif.byte_ready);
    end
    @(negedge clk);
    bif.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int max_cycles);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_done_timeout: load_done=%0b want 1", load_done);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %0b want 1", cpu_hold); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %0b want 0", load_done); end
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %0b want 0", load_err); end
    n_checks++; if (bif.byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %0b want 0", bif.byte_ready); end
    n_checks++; if (bif.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b want 0", bif.wr_en); end
    n_checks++; if (bif.wr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", bif.wr_addr); end
    n_checks++; if (bif.wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", bif.wr_data); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold_after: got %0b want 1", cpu_hold); end
  endtask

  task automatic test_basic_load();
    logic [7:0] b [8];
    logic [8:0] rdy;
    int k;
    b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    k = 0;
    clear_log();
    start_load(7'd2);
    for (int c = 0; c < 9; c++) begin
      rdy[8-c]       = bif.byte_ready;
      bif.byte_valid = 1'b1;
      bif.byte_data  = b[k];
      if (bif.byte_ready === 1'b1) k++;
      @(negedge clk);
    end
    bif.byte_valid = 1'b0;
    n_checks++; if (rdy !== 9'b1111_0_1111) begin n_fail++; $display("FAIL t1_ready_pattern: got %b want 111101111", rdy); end
    n_checks++; if (k != 8) begin n_fail++; $display("FAIL t1_bytes_accepted: got %0d want 8", k); end
    // Now in WRITE for word 1; strobe appears next cycle.
    n_checks++; if (bif.wr_en !== 1'b0) begin n_fail++; $display("FAIL t1_wr_en_in_write: got %0b want 0", bif.wr_en); end
    @(negedge clk);
    n_checks++; if (bif.wr_en !== 1'b1) begin n_fail++; $display("FAIL t1_wr_en_last: got %0b want 1", bif.wr_en); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t1_hold_at_last_wr: got %0b want 1", cpu_hold); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL t1_done_at_last_wr: got %0b want 0", load_done); end
    @(negedge clk);
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL t1_hold_after: got %0b want 0", cpu_hold); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL t1_done_after: got %0b want 1", load_done); end
    n_checks++; if (wa_q.size() != 2) begin n_fail++; $display("FAIL t1_write_count: got %0d want 2", wa_q.size()); end
    else begin
      n_checks++; if (wa_q[0] !== 32'h0) begin n_fail++; $display("FAIL t1_addr0: got %h want 00000000", wa_q[0]); end
      n_checks++; if (wd_q[0] !== 32'h00500513) begin n_fail++; $display("FAIL t1_data0: got %h want 00500513", wd_q[0]); end
      n_checks++; if (wa_q[1] !== 32'h4) begin n_fail++; $display("FAIL t1_addr1: got %h want 00000004", wa_q[1]); end
      n_checks++; if (wd_q[1] !== 32'h00100593) begin n_fail++; $display("FAIL t1_data1: got %h want 00100593", wd_q[1]); end
    end
  endtask

  task automatic test_valid_gaps();
    clear_log();
    start_load(7'd2);
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL t2_done_cleared: got %0b want 0", load_done); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t2_hold_set: got %0b want 1", cpu_hold); end
    send_word(32'h00500513, 1'b1);
    send_word(32'h00100593, 1'b1);
    wait_done(20);
    n_checks++; if (wa_q.size() != 2) begin n_fail++; $display("FAIL t2_write_count: got %0d want 2", wa_q.size()); end
    else begin
      n_checks++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00500513) begin n_fail++; $display("FAIL t2_word0: got %h/%h want 00000000/00500513", wa_q[0], wd_q[0]); end
      n_checks++; if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00100593) begin n_fail++; $display("FAIL t2_word1: got %h/%h want 00000004/00100593", wa_q[1], wd_q[1]); end
    end
  endtask

  task automatic test_bad_len();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    start_load(7'd0);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL t3_err_len0: got %0b want 1", load_err); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t3_hold_len0: got %0b want 1", cpu_hold); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL t3_done_len0: got %0b want 0", load_done); end
    repeat (3) @(negedge clk);
    n_checks++; if (bif.byte_ready !== 1'b0) begin n_fail++; $display("FAIL t3_stay_idle: byte_ready=%0b want 0", bif.byte_ready); end
    // Valid single-word load clears the error.
    start_load(7'd1);
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL t3_err_cleared: got %0b want 0", load_err); end
    send_word(32'hDEADBEEF, 1'b0);
    wait_done(20);
    n_checks++; if (wa_q.size() != 1) begin n_fail++; $display("FAIL t3_write_count: got %0d want 1", wa_q.size()); end
    else begin
      n_checks++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t3_word: got %h/%h want 00000000/deadbeef", wa_q[0], wd_q[0]); end
    end
    // Oversize request after a good load: error set, hold and done untouched.
    start_load(7'd65);
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL t3_err_len65: got %0b want 1", load_err); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL t3_done_kept: got %0b want 1", load_done); end
    n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL t3_hold_kept: got %0b want 0", cpu_hold); end
    repeat (3) @(negedge clk);
    n_checks++; if (bif.byte_ready !== 1'b0 || wa_q.size() != 1) begin n_fail++; $display("FAIL t3_len65_idle: ready=%0b writes=%0d want 0/1", bif.byte_ready, wa_q.size()); end
  endtask

  task automatic test_full_depth();
    logic [31:0] exp;
    clear_log();
    start_load(7'd64);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    wait_done(20);
    repeat (2) @(negedge clk);
    n_checks++; if (wa_q.size() != 64) begin n_fail++; $display("FAIL t4_write_count: got %0d want 64", wa_q.size()); end
    else begin
      for (int i = 0; i < 64; i++) begin
        exp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        n_checks++;
        if (wa_q[i] !== 32'(4*i) || wd_q[i] !== exp) begin
          n_fail++;
          $display("FAIL t4_word%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i], 32'(4*i), exp);
        end
      end
      n_checks++; if (wa_q[63] !== 32'hFC || wd_q[63] !== 32'hFFFEFDFC) begin n_fail++; $display("FAIL t4_last: got %h/%h want 000000fc/fffefdfc", wa_q[63], wd_q[63]); end
    end
  endtask

  task automatic test_abort_recv();
    clear_log();
    start_load(7'd3);
    send_word(32'h44332211, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    // Abort together with an offered byte: abort must win.
    abort          = 1'b1;
    bif.byte_valid = 1'b1;
    bif.byte_data  = 8'h77;
    @(negedge clk);
    abort          = 1'b0;
    bif.byte_valid = 1'b0;
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL t5_err: got %0b want 1", load_err); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t5_hold: got %0b want 1", cpu_hold); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL t5_done: got %0b want 0", load_done); end
    n_checks++; if (bif.byte_ready !== 1'b0) begin n_fail++; $display("FAIL t5_idle: byte_ready=%0b want 0", bif.byte_ready); end
    repeat (6) @(negedge clk);
    n_checks++; if (wa_q.size() != 1) begin n_fail++; $display("FAIL t5_write_count: got %0d want 1", wa_q.size()); end
    else begin
      n_checks++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h44332211) begin n_fail++; $display("FAIL t5_word0: got %h/%h want 00000000/44332211", wa_q[0], wd_q[0]); end
    end
    clear_log();
    start_load(7'd1);
    send_word(32'hCAFEF00D, 1'b0);
    wait_done(20);
    n_checks++; if (wa_q.size() != 1 || wd_q[0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t5_reload: writes=%0d want 1 with data cafef00d", wa_q.size()); end
    n_checks++; if (load_err !== 1'b0 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL t5_reload_flags: err=%0b hold=%0b want 0/0", load_err, cpu_hold); end
  endtask

  task automatic test_abort_write();
    clear_log();
    start_load(7'd2);
    send_word(32'h12345678, 1'b0);
    // Now in WRITE for word 0.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (bif.wr_en !== 1'b0) begin n_fail++; $display("FAIL t5w_wr_en: got %0b want 0", bif.wr_en); end
    n_checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL t5w_flags: err=%0b hold=%0b want 1/1", load_err, cpu_hold); end
    repeat (4) @(negedge clk);
    n_checks++; if (wa_q.size() != 0) begin n_fail++; $display("FAIL t5w_write_count: got %0d want 0", wa_q.size()); end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    start_load(7'd2);
    send_word(32'hA1B2C3D4, 1'b0);
    send_byte(8'hEE);
    send_byte(8'hFF);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin n_fail++; $display("FAIL t6_flags: hold=%0b done=%0b err=%0b want 1/0/0", cpu_hold, load_done, load_err); end
    n_checks++; if (bif.byte_ready !== 1'b0 || bif.wr_en !== 1'b0) begin n_fail++; $display("FAIL t6_handshake: ready=%0b wr_en=%0b want 0/0", bif.byte_ready, bif.wr_en); end
    n_checks++; if (bif.wr_addr !== 32'h0 || bif.wr_data !== 32'h0) begin n_fail++; $display("FAIL t6_bus: addr=%h data=%h want 0/0", bif.wr_addr, bif.wr_data); end
    bif.byte_valid = 1'b1;
    bif.byte_data  = 8'h5A;
    repeat (10) @(negedge clk);
    bif.byte_valid = 1'b0;
    n_checks++; if (wa_q.size() != 1) begin n_fail++; $display("FAIL t6_write_count: got %0d want 1", wa_q.size()); end
    else begin
      n_checks++; if (wd_q[0] !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL t6_word0: got %h want a1b2c3d4", wd_q[0]); end
    end
  endtask

  initial begin
    bif.byte_valid = 1'b0;
    bif.byte_data  = '0;
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_valid_gaps();
    test_bad_len();
    test_full_depth();
    test_abort_recv();
    test_abort_write();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side companion to the single-cycle processor's 64-word instruction memory. Accepts a program as a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. Issues one write strobe per word to the instruction memory's write port. Holds the processor in stall until the full program is written.

Parameters:
DEPTH, 64, instruction memory depth in 32-bit words (256 bytes)
LEN_W, 7, width of load_len; must hold values up to DEPTH

Ports:
clk  input  1  processor clock, rising edge
rst_n  input  1  synchronous active-low reset
load_start  input  1  one-cycle request to begin a load; sampled only in IDLE
load_len  input  LEN_W  number of words to load; sampled with load_start
abort  input  1  cancels an in-progress load
byte_valid  input  1  byte_data is valid
byte_data  input  8  program byte, ascending address order
byte_ready  output  1  loader accepts byte this cycle
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  32  byte address of word written, {word_idx, 2'b00}
wr_data  output  32  packed instruction word
cpu_hold  output  1  stalls processor fetch while high
load_done  output  1  sticky: last load completed successfully
load_err  output  1  sticky: last request was rejected or aborted

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, load_done=0, load_err=0.
  - cpu_hold=1: the processor stays stalled until the first successful load.
  - Reset mid-load discards any partial word and writes nothing further.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready=0.
  - On load_start=1 with load_len==0 or load_len>DEPTH: set load_err=1, stay in IDLE, leave cpu_hold and load_done unchanged.
  - On load_start=1 with a valid load_len: latch len, clear word_idx and byte_idx, set cpu_hold=1, load_done=0, load_err=0, go to RECV.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready. It is placed in assembly bits [8*byte_idx+7 : 8*byte_idx], then byte_idx increments.
  - On the 4th accepted byte (byte_idx==3), go to WRITE next cycle.
  - With byte_valid=0, wait indefinitely; there is no timeout.
- WRITE:
  - byte_ready=0.
  - wr_en=1 for exactly one cycle, with wr_addr={word_idx,2'b00} and wr_data=assembled word.
  - If word_idx==len-1, go to DONE. Otherwise increment word_idx, clear byte_idx, go to RECV.
- DONE (one cycle): set load_done=1, cpu_hold=0, go to IDLE.
- Signal timing:
  - The cpu_hold fall and the load_done rise take effect the cycle after the final wr_en.
  - load_done stays high until the next accepted load_start.
- Minimum throughput: 5 cycles per word (4 accept cycles + 1 write cycle).
- wr_en is never asserted for a partially assembled word.
- abort=1 in RECV or WRITE:
  - Takes priority over a byte handshake or write in the same cycle; wr_en stays 0 that cycle.
  - Go to IDLE with load_err=1 and cpu_hold=1; the partial word is discarded.
  - Words already written remain in memory.
- abort in IDLE or DONE is ignored.
- load_start outside IDLE is ignored.
- Word index never exceeds DEPTH-1, and wr_addr never exceeds 32'h0000_00FC.

Test Plan:
1. Reset then load_len=2, bytes 13,05,50,00,93,05,10,00 with valid held high -> wr_en at word 0: addr 0x0, data 0x00500513; at word 1: addr 0x4, data 0x00100593. cpu_hold falls and load_done=1 one cycle after the second wr_en. 9-cycle byte_ready pattern 1111 0 1111.
2. Same stream with byte_valid toggled 1,0,1,0 -> identical wr_data/wr_addr sequence. byte_idx advances only on handshake cycles.
3. load_len=0, then load_len=65 -> load_err=1, state stays IDLE, no wr_en, cpu_hold stays 1. Then load_len=1 with bytes EF,BE,AD,DE -> wr_data 0xDEADBEEF at addr 0, load_err cleared.
4. load_len=64, incrementing bytes 0x00..0xFF -> 64 writes; last write at addr 0xFC with data 0xFFFEFDFC. No write beyond 0xFC.
5. load_len=3, abort asserted after 6 bytes accepted -> exactly one wr_en (addr 0). load_err=1, cpu_hold=1, load_done=0, state IDLE. A subsequent load_len=1 load succeeds.
6. rst_n=0 for one cycle mid-RECV of word 1 -> all outputs at reset values next cycle, including cpu_hold=1. No further wr_en until a new load_start.
